pu_io_order_arb: RTL

//  Multi-thread PU I/O request arbiter: buffers per-thread memory/IO requests, enforces atomic aq/rl ordering, and round-robin issues one request per cycle to the shared PU memory port.

---
 rtl/pu_io_pkg.sv | 42 ++++
 rtl/pu_io_fifo.sv | 80 ++++++++
 rtl/pu_io_order_arb.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pu_io_pkg.sv
// ---------------------------------------------------------------------------
// pu_io_pkg
// Shared types for the PU I/O request path.
//   io_req_t      : packed I/O request (atomic, aq, rl, funct5, wr, addr,
//                   wdata, tid, fid), MSB first in that order
//   IO_REQ_NBITS  : width of io_req_t
//   thr_idx_w()   : width of a thread index for a given thread count
// The address width comes from `PU_MEM_DEPTH_NBITS. A default of 16 is
// supplied when the surrounding build does not define it.
// ---------------------------------------------------------------------------
`ifndef PU_MEM_DEPTH_NBITS
`define PU_MEM_DEPTH_NBITS 16
`endif

package pu_io_pkg;

    localparam int IO_ADDR_NBITS = `PU_MEM_DEPTH_NBITS;
    localparam int IO_DATA_NBITS = 32;
    localparam int IO_TID_NBITS  = 4;
    localparam int IO_FID_NBITS  = 4;

    typedef struct packed {
        logic                     atomic;
        logic                     aq;
        logic                     rl;
        logic [4:0]               funct5;
        logic                     wr;
        logic [IO_ADDR_NBITS-1:0] addr;
        logic [IO_DATA_NBITS-1:0] wdata;
        logic [IO_TID_NBITS-1:0]  tid;
        logic [IO_FID_NBITS-1:0]  fid;
    } io_req_t;

    localparam int IO_REQ_NBITS = $bits(io_req_t);

    // A single-bit index is kept even for one or two threads so that
    // index ports never collapse to zero width.
    function automatic int thr_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pu_io_fifo.sv
// ---------------------------------------------------------------------------
// pu_io_fifo
// Single-clock FIFO of io_req_t, DEPTH entries (power of 2, >= 2).
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   i_push      : write i_data (caller only pushes while o_ready is high)
//   i_data      : request to store
//   i_pop       : drop the head entry (ignored when empty)
//   o_data      : head entry, valid while !o_empty
//   o_empty     : FIFO holds no entries
//   o_ready     : registered "not full"; low during reset
// ---------------------------------------------------------------------------
module pu_io_fifo
    import pu_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_push,
    input  io_req_t i_data,
    input  logic    i_pop,
    output io_req_t o_data,
    output logic    o_empty,
    output logic    o_ready
);

    localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

    io_req_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_ready;
    logic [PTR_W:0]   w_count_nxt;
    logic             w_do_pop;

    assign w_do_pop = i_pop & ~o_empty;
    assign o_empty  = (r_count == '0);
    assign o_data   = r_mem[r_rd_ptr];
    assign o_ready  = r_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (i_push && !w_do_pop) begin
            w_count_nxt = r_count + (PTR_W+1)'(1);
        end else if (!i_push && w_do_pop) begin
            w_count_nxt = r_count - (PTR_W+1)'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2. Ready is
    // computed from the post-update occupancy, so a full FIFO that pops
    // this cycle only reopens on the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != (PTR_W+1)'(DEPTH));
        end
    end

    // Storage carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/pu_io_order_arb.sv
// ---------------------------------------------------------------------------
// pu_io_order_arb
// Multi-thread PU I/O request arbiter. Each thread has a small FIFO; heads
// that satisfy ordering rules (aq blocking, atomic aq/rl drain, outstanding
// limit) compete round-robin for the shared memory port, one grant per
// cycle.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   in_valid/in_ready      : per-thread push handshake (in_ready registered)
//   in_req                 : per-thread request
//   out_valid/out_ready    : memory-port handshake
//   out_req, out_thr       : granted request and its thread (0 when idle)
//   rsp_valid, rsp_thr     : one completion, in issue order per thread
//   outst_cnt              : 4 bits per thread, outstanding requests
//   err_rsp                : sticky, completion arrived with nothing open
//   stat_grant             : 16 bits per thread, saturating grant counts
// Build option: define PU_IO_ARB_STATS_EN to implement the grant counters;
// otherwise stat_grant is constant zero and no counter flops exist.
//
// Handshake: a transfer happens on any cycle where valid and ready are both
// high. Once out_valid is raised without out_ready, the granted thread and
// request are frozen (lock) until accepted; in_valid/in_ready follow the
// same rule per thread.
// ---------------------------------------------------------------------------
`ifndef PU_MEM_DEPTH_NBITS
`define PU_MEM_DEPTH_NBITS 16
`endif

module pu_io_order_arb
    import pu_io_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int DEPTH       = 4,
    parameter int MAX_OUTST   = 4,
    parameter int ADDR_NBITS  = `PU_MEM_DEPTH_NBITS
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_THREADS-1:0]              in_valid,
    output logic [NUM_THREADS-1:0]              in_ready,
    input  io_req_t [NUM_THREADS-1:0]           in_req,
    output logic                                out_valid,
    input  logic                                out_ready,
    output io_req_t                             out_req,
    output logic [thr_idx_w(NUM_THREADS)-1:0]   out_thr,
    input  logic                                rsp_valid,
    input  logic [thr_idx_w(NUM_THREADS)-1:0]   rsp_thr,
    output logic [4*NUM_THREADS-1:0]            outst_cnt,
    output logic                                err_rsp,
    output logic [16*NUM_THREADS-1:0]           stat_grant
);

    localparam int         THR_W       = thr_idx_w(NUM_THREADS);
    localparam logic [3:0] MAX_OUTST_C = 4'(MAX_OUTST);

    io_req_t                w_head [NUM_THREADS];
    logic [NUM_THREADS-1:0] w_empty;
    logic [NUM_THREADS-1:0] w_elig;
    logic [NUM_THREADS-1:0] w_pop;
    logic [NUM_THREADS-1:0] w_rsp_zero;

    logic                   w_rr_found;
    logic [THR_W-1:0]       w_rr_thr;
    int                     w_rr_idx;
    logic [THR_W-1:0]       w_gnt_thr;
    io_req_t                w_gnt_req;
    logic                   w_grant;

    logic                   r_lock;
    logic [THR_W-1:0]       r_lock_thr;
    logic [THR_W-1:0]       r_rr_ptr;
    logic                   r_err_rsp;

    // -----------------------------------------------------------------
    // Per-thread FIFO, outstanding count, aq block, optional stats
    // -----------------------------------------------------------------
    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
        logic [3:0] r_outst;
        logic       r_aq_blk;
        logic       w_push;
        logic       w_rsp_hit;
        logic       w_rsp_dec;

        assign w_push    = in_valid[t] & in_ready[t];
        assign w_rsp_hit = rsp_valid & (rsp_thr == THR_W'(t));
        assign w_rsp_dec = w_rsp_hit & (r_outst != 4'd0);
        assign w_rsp_zero[t] = w_rsp_hit & (r_outst == 4'd0);
        assign w_pop[t]  = w_grant & (w_gnt_thr == THR_W'(t));

        pu_io_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push),
            .i_data  (in_req[t]),
            .i_pop   (w_pop[t]),
            .o_data  (w_head[t]),
            .o_empty (w_empty[t]),
            .o_ready (in_ready[t])
        );

        // An atomic with aq or rl must wait until everything earlier on
        // this thread has completed.
        assign w_elig[t] = ~w_empty[t] & ~r_aq_blk & (r_outst < MAX_OUTST_C)
                         & ~(w_head[t].atomic & (w_head[t].aq | w_head[t].rl)
                             & (r_outst != 4'd0));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_outst  <= 4'd0;
                r_aq_blk <= 1'b0;
            end else begin
                if (w_pop[t] && !w_rsp_dec) begin
                    r_outst <= r_outst + 4'd1;
                end else if (!w_pop[t] && w_rsp_dec) begin
                    r_outst <= r_outst - 4'd1;
                end
                // A new aq grant wins over a same-cycle completion.
                if (w_pop[t] && w_head[t].atomic && w_head[t].aq) begin
                    r_aq_blk <= 1'b1;
                end else if (w_rsp_hit) begin
                    r_aq_blk <= 1'b0;
                end
            end
        end

        assign outst_cnt[4*t +: 4] = r_outst;

`ifdef PU_IO_ARB_STATS_EN
        logic [15:0] r_stat_cnt;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_stat_cnt <= 16'h0;
            end else if (w_pop[t] && (r_stat_cnt != 16'hFFFF)) begin
                r_stat_cnt <= r_stat_cnt + 16'h1;
            end
        end
        assign stat_grant[16*t +: 16] = r_stat_cnt;
`else
        assign stat_grant[16*t +: 16] = 16'h0;
`endif
    end

    // -----------------------------------------------------------------
    // Round-robin pick starting at r_rr_ptr
    // -----------------------------------------------------------------
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_thr   = '0;
        w_rr_idx   = 0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            w_rr_idx = int'(r_rr_ptr) + i;
            if (w_rr_idx >= NUM_THREADS) begin
                w_rr_idx = w_rr_idx - NUM_THREADS;
            end
            if (!w_rr_found && w_elig[w_rr_idx[THR_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_thr   = w_rr_idx[THR_W-1:0];
            end
        end
    end

    // A locked thread keeps the port regardless of the round-robin view;
    // its head cannot change and only completions touch its eligibility,
    // which can only make it more eligible.
    assign w_gnt_thr = r_lock ? r_lock_thr : w_rr_thr;
    assign w_gnt_req = w_head[w_gnt_thr];
    assign out_valid = r_lock | w_rr_found;
    assign w_grant   = out_valid & out_ready;
    assign out_thr   = out_valid ? w_gnt_thr : '0;

    always_comb begin
        out_req = '0;
        if (out_valid) begin
            out_req      = w_gnt_req;
            out_req.addr = IO_ADDR_NBITS'(w_gnt_req.addr[ADDR_NBITS-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lock     <= 1'b0;
            r_lock_thr <= '0;
            r_rr_ptr   <= '0;
            r_err_rsp  <= 1'b0;
        end else begin
            if (out_valid && !out_ready) begin
                r_lock     <= 1'b1;
                r_lock_thr <= w_gnt_thr;
            end else if (w_grant) begin
                r_lock <= 1'b0;
            end
            if (w_grant) begin
                r_rr_ptr <= (w_gnt_thr == THR_W'(NUM_THREADS - 1)) ? '0
                                                                   : w_gnt_thr + THR_W'(1);
            end
            if (|w_rsp_zero) begin
                r_err_rsp <= 1'b1;
            end
        end
    end

    assign err_rsp = r_err_rsp;

endmodule
